debounce_edge: RTL and testbench
================================

Name: debounce_edge

Overview:
- Downstream consumer of the input synchronizer's `sync_out`.
- Takes the already-synchronized level, rejects glitches shorter than DEBOUNCE_CYCLES clocks, and tracks a debounced level.
- Emits one-cycle press/release pulses and keeps a saturating press counter for the control logic.
- Sits between the synchronizer and any FSM that consumes button or strobe events.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive samples at a new level required before the debounced level changes; legal range 1..255.
- IDLE_LEVEL, 1'b1, debounced level after reset. 1 when fed by the high-idle synchronizer; the active (pressed) level is ~IDLE_LEVEL.
- COUNT_WIDTH, 8, width of press_count.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sync_in  in  1  synchronized level from the upstream synchronizer.
- clr  in  1  synchronous clear of press_count and overflow.
- level_out  out  1  debounced level.
- press_pulse  out  1  one-cycle pulse when level_out changes to ~IDLE_LEVEL.
- release_pulse  out  1  one-cycle pulse when level_out returns to IDLE_LEVEL.
- press_count  out  COUNT_WIDTH  number of presses since reset/clr, saturating.
- overflow  out  1  sticky; set when a press arrives while press_count is all-ones.

Behaviour:
- Reset (rst=1 at a rising edge), regardless of state:
  - FSM=IDLE, stable counter=0.
  - level_out=IDLE_LEVEL, press_pulse=0, release_pulse=0.
  - press_count=0, overflow=0.
- States: IDLE (level_out=IDLE_LEVEL), QUAL_ACT, ACTIVE (level_out=~IDLE_LEVEL), QUAL_IDLE.
- Stable counter width is $clog2(DEBOUNCE_CYCLES+1). It counts consecutive samples differing from level_out.
- IDLE:
  - sync_in==IDLE_LEVEL: stay, cnt=0.
  - Otherwise: if DEBOUNCE_CYCLES==1, go directly to ACTIVE with press event; else go to QUAL_ACT, cnt=1.
- QUAL_ACT:
  - sync_in==IDLE_LEVEL: back to IDLE, cnt=0 (glitch rejected, no pulse).
  - Else if cnt==DEBOUNCE_CYCLES-1: go to ACTIVE, cnt=0, press event.
  - Else cnt+1.
- ACTIVE / QUAL_IDLE: mirror of IDLE / QUAL_ACT with levels swapped; completion gives a release event.
- Latency:
  - First new-level sample at edge k: level_out and the pulse update at edge k+DEBOUNCE_CYCLES-1 and are visible after that edge.
  - Pulses are registered and high for exactly one cycle.
- Press event:
  - press_pulse=1 next cycle.
  - press_count+1 unless already all-ones; in that case hold and set overflow=1.
- Release event: release_pulse=1 next cycle; counter unaffected.
- clr: press_count=0 and overflow=0. If a press event occurs the same cycle, clr wins (count 0), but press_pulse still asserts.
- Priority: rst > clr > increment.
- sync_in=X: treated as not equal to IDLE_LEVEL by the compare. No X may propagate to outputs after reset; the bench checks outputs are 0/1 only.
- No combinational path from any input to any output.

Decomposition:
- Package debounce_pkg:
  - state_t enum {IDLE, QUAL_ACT, ACTIVE, QUAL_IDLE}.
  - Function for the stable-counter width.
- One sub-module, stable_counter: clear/enable counter with rollover-compare output `done` at a programmable value, reused for the qualification count.
- The FSM, pulse registers and press counter live in debounce_edge.

Test Plan (DEBOUNCE_CYCLES=4, IDLE_LEVEL=1, COUNT_WIDTH=3):
- Reset: rst=1 for 2 cycles with sync_in=0 → level_out=1, both pulses 0, press_count=0, overflow=0 during and after reset.
- Glitch rejection: sync_in=0 for 3 cycles then 1 → level_out stays 1, no pulses, press_count=0.
- Clean press/release:
  - sync_in=0 from edge k → press_pulse high for exactly the one cycle after edge k+3; level_out=0; press_count=1.
  - sync_in=1 held 4 cycles → release_pulse high for one cycle, level_out=1.
- Saturation: 8 clean presses → press_count=7 with overflow=1 after the 8th; clr → press_count=0, overflow=0.
- Simultaneous events:
  - clr asserted in the cycle of a press event → press_count=0, press_pulse=1.
  - rst asserted mid-QUAL_ACT (cnt=2) → next cycle back to IDLE, cnt=0, no pulse.
- Metastable stream: sync_in=X for 20 cycles, then 1 → outputs never X; level_out returns to 1 within 4 cycles of X ending.

Source files
------------

// File: rtl/debounce_edge_pkg.sv
// Shared types and sizing helper for the debounce/edge-detect block.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE,
    QUAL_ACT,
    ACTIVE,
    QUAL_IDLE
  } state_t;

  // Bits needed to hold a qualification count of 0..cycles.
  function automatic int stable_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_edge_stable_counter.sv
// Clear/enable counter that flags when it sits at a programmable target and
// rolls back to zero when enabled at that point.
module stable_counter
  import debounce_pkg::*;
#(
  parameter int MAX_COUNT = 4,
  parameter int W         = stable_cnt_width(MAX_COUNT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] target,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign done = (cnt_q == target);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = done ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/debounce_edge.sv
// Debounces an already-synchronized level, emits registered press/release
// pulses and keeps a saturating press counter with a sticky overflow flag.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic IDLE_LEVEL      = 1'b1,
  parameter int   COUNT_WIDTH     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sync_in,
  input  logic                   clr,
  output logic                   level_out,
  output logic                   press_pulse,
  output logic                   release_pulse,
  output logic [COUNT_WIDTH-1:0] press_count,
  output logic                   overflow
);

  localparam int CNT_W = stable_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t                 state_q, state_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   ovf_q, ovf_d;

  logic in_idle;
  logic cnt_clr;
  logic cnt_en;
  logic cnt_done;

  stable_counter #(
    .MAX_COUNT (DEBOUNCE_CYCLES),
    .W         (CNT_W)
  ) u_stable_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .target (CNT_TARGET),
    .done   (cnt_done)
  );

  // An unknown sample falls into the else branch, i.e. counts as "not idle".
  assign in_idle = (sync_in == IDLE_LEVEL);

  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE, QUAL_ACT: begin
        if (in_idle) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
          if (cnt_done) begin
            state_d = ACTIVE;
            press_d = 1'b1;
          end else begin
            state_d = QUAL_ACT;
          end
        end
      end
      ACTIVE, QUAL_IDLE: begin
        if (in_idle) begin
          cnt_en = 1'b1;
          if (cnt_done) begin
            state_d   = IDLE;
            release_d = 1'b1;
          end else begin
            state_d = QUAL_IDLE;
          end
        end else begin
          state_d = ACTIVE;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (press_d) begin
      level_d = ~IDLE_LEVEL;
    end else if (release_d) begin
      level_d = IDLE_LEVEL;
    end
  end

  // clr beats the increment; the press pulse itself is unaffected by clr.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (press_d) begin
      if (&count_q) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      level_q   <= IDLE_LEVEL;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  assign level_out     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign press_count   = count_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: directed scenarios plus random level runs, all
// checked against a run-length model of the debounce rules.
module tb_debounce_edge;

  localparam int   D        = 4;
  localparam logic IDLE_LVL = 1'b1;
  localparam int   CW       = 3;
  localparam int   CMAX     = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          sync_in;
  logic          clr;
  logic          level_out;
  logic          press_pulse;
  logic          release_pulse;
  logic [CW-1:0] press_count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  // Reference state: current debounced level and length of the current run
  // of samples disagreeing with it.
  logic m_level;
  int   m_run;
  int   m_count;
  logic m_ovf;
  logic m_press;
  logic m_rel;

  debounce_edge #(
    .DEBOUNCE_CYCLES (D),
    .IDLE_LEVEL      (IDLE_LVL),
    .COUNT_WIDTH     (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sync_in       (sync_in),
    .clr           (clr),
    .level_out     (level_out),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .press_count   (press_count),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    logic s_idle;
    logic l_idle;
    @(posedge clk);
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (rst) begin
      m_level = IDLE_LVL;
      m_run   = 0;
      m_count = 0;
      m_ovf   = 1'b0;
    end else begin
      s_idle = (sync_in === IDLE_LVL);
      l_idle = (m_level == IDLE_LVL);
      if (s_idle == l_idle) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == D) begin
          m_run   = 0;
          m_level = ~m_level;
          if (l_idle) m_press = 1'b1;
          else        m_rel   = 1'b1;
        end
      end
      if (clr) begin
        m_count = 0;
        m_ovf   = 1'b0;
      end else if (m_press) begin
        if (m_count == CMAX) m_ovf = 1'b1;
        else                 m_count++;
      end
    end
    #1;
    check("xprop", 32'($isunknown({level_out, press_pulse, release_pulse, press_count, overflow})), 32'd0);
    check("level", level_out, m_level);
    check("press", press_pulse, m_press);
    check("release", release_pulse, m_rel);
    check("count", press_count, m_count);
    check("ovf", overflow, m_ovf);
  endtask

  task automatic drive(input logic s, input logic c, input int n);
    rst     = 1'b0;
    sync_in = s;
    clr     = c;
    repeat (n) tick();
  endtask

  initial begin
    int lat;
    int len;
    logic lvl;
    m_level = IDLE_LVL;
    m_run   = 0;
    m_count = 0;
    m_ovf   = 1'b0;

    // Reset held with the input at the active level.
    rst = 1'b1; sync_in = 1'b0; clr = 1'b0;
    repeat (2) tick();
    check("rst_level", level_out, 1);
    check("rst_count", press_count, 0);
    drive(1'b1, 1'b0, 1);

    // Glitch of D-1 samples is rejected.
    drive(1'b0, 1'b0, 3);
    drive(1'b1, 1'b0, 2);
    check("glitch_level", level_out, 1);
    check("glitch_count", press_count, 0);

    // Clean press: pulse after the D-th consecutive active sample.
    lat = 0;
    sync_in = 1'b0;
    for (int i = 1; i <= D; i++) begin
      tick();
      if (press_pulse && lat == 0) lat = i;
    end
    check("press_lat", lat, D);
    drive(1'b0, 1'b0, 1);
    check("press_level", level_out, 0);
    check("press_count1", press_count, 1);
    drive(1'b1, 1'b0, D);
    check("release_level", level_out, 1);
    drive(1'b1, 1'b0, 1);

    // Saturation and clear.
    drive(1'b1, 1'b1, 1);
    repeat (8) begin
      drive(1'b0, 1'b0, D);
      drive(1'b1, 1'b0, D);
    end
    check("sat_count", press_count, CMAX);
    check("sat_ovf", overflow, 1);
    drive(1'b1, 1'b1, 1);
    check("clr_count", press_count, 0);
    check("clr_ovf", overflow, 0);

    // clr in the same cycle as a press event.
    drive(1'b0, 1'b0, D - 1);
    drive(1'b0, 1'b1, 1);
    check("clrpress_pulse", press_pulse, 1);
    check("clrpress_count", press_count, 0);
    drive(1'b1, 1'b0, D + 1);

    // Reset in the middle of qualification restarts the run.
    drive(1'b0, 1'b0, 2);
    rst = 1'b1; sync_in = 1'b0;
    tick();
    check("midrst_pulse", press_pulse, 0);
    drive(1'b0, 1'b0, D - 1);
    check("midrst_level", level_out, 1);
    drive(1'b0, 1'b0, 1);
    check("midrst_press", level_out, 0);
    drive(1'b1, 1'b0, D + 1);

    // Unknown input stream, then back to idle.
    drive(1'bx, 1'b0, 20);
    drive(1'b1, 1'b0, D);
    check("x_recover", level_out, 1);

    // Random runs of levels with occasional clr and reset.
    for (int r = 0; r < 500; r++) begin
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 2 * D));
      for (int j = 0; j < len; j++) begin
        rst     = ($urandom_range(0, 299) == 0);
        clr     = ($urandom_range(0, 39) == 0);
        sync_in = lvl;
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
